// File: rtl/move_request_gen_if.sv
// Handshake bundle between the button front end and the sprite draw FSM.
// The block under control connects through the slave modport; the driver of
// buttons, tick, position and ack connects through the master modport.
interface move_request_gen_if;
  logic [3:0] btn_in;
  logic       tick;
  logic [6:0] x_pos;
  logic [6:0] y_pos;
  logic       ack;
  logic [3:0] dir_out;
  logic       moved;

  modport master (
    output btn_in, tick, x_pos, y_pos, ack,
    input  dir_out, moved
  );

  modport slave (
    input  btn_in, tick, x_pos, y_pos, ack,
    output dir_out, moved
  );
endinterface

// File: rtl/move_request_gen.sv
// move_request_gen: conditions four raw direction buttons (2-FF sync +
// per-bit debounce), cancels opposing presses, masks moves that would push
// the 4x4 sprite off-screen and issues a held move request on the frame tick
// until the draw FSM acknowledges it.
// Optional feature macro: AUTO_REPEAT_EN (held buttons re-request every tick;
// when undefined each press yields exactly one move).
// Button bit map: [0]=right [1]=up [2]=down [3]=left.
module move_request_gen #(
  parameter int         DEB_CYCLES = 1000000,
  parameter int         CNT_W      = 20,
  parameter logic [6:0] X_MAX      = 7'd124,
  parameter logic [6:0] Y_MAX      = 7'd116
) (
  input logic               clk,
  input logic               reset,
  move_request_gen_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  typedef enum logic {S_IDLE, S_REQ} state_t;

  state_t           state, state_d;
  logic [3:0]       sync_p0, sync_p1;
  logic [3:0]       stable;
  logic [CNT_W-1:0] cnt [4];
  logic [3:0]       resolved, masked, qualify, cand;
  logic [3:0]       dir_q, dir_d;
  logic             capture;

  // Two-flop synchronizer for the asynchronous button inputs
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= bus.btn_in;
      sync_p1 <= sync_p0;
    end
  end

  // Per-bit debounce: accept a new level only after DEB_CYCLES consecutive disagreeing samples
  always_ff @(posedge clk) begin
    if (reset) begin
      stable <= '0;
      for (int i = 0; i < 4; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (sync_p1[i] == stable[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          stable[i] <= sync_p1[i];
          cnt[i]    <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // Cancel opposing presses, then drop moves that would leave the screen
  always_comb begin
    resolved = stable;
    if (stable[0] && stable[3]) begin
      resolved[0] = 1'b0;
      resolved[3] = 1'b0;
    end
    if (stable[1] && stable[2]) begin
      resolved[1] = 1'b0;
      resolved[2] = 1'b0;
    end
    masked = resolved;
    if (bus.x_pos >= X_MAX)  masked[0] = 1'b0;
    if (bus.y_pos == 7'd0)   masked[1] = 1'b0;
    if (bus.y_pos >= Y_MAX)  masked[2] = 1'b0;
    if (bus.x_pos == 7'd0)   masked[3] = 1'b0;
  end

`ifdef AUTO_REPEAT_EN
  assign qualify = 4'hF;
`else
  logic [3:0] armed;

  // A captured bit disarms until its debounced level returns to 0 (one move per press)
  always_ff @(posedge clk) begin
    if (reset) begin
      armed <= 4'hF;
    end else begin
      armed <= (armed | ~stable) & ~(capture ? cand : 4'h0);
    end
  end

  assign qualify = armed;
`endif

  assign cand = masked & qualify;

  // State and latched direction registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      dir_q <= '0;
    end else begin
      state <= state_d;
      dir_q <= dir_d;
    end
  end

  // Next-state logic: capture on tick while idle, hold until ack
  always_comb begin
    state_d = state;
    dir_d   = dir_q;
    capture = 1'b0;
    case (state)
      S_IDLE: begin
        dir_d = 4'h0;
        if (bus.tick && (cand != 4'h0)) begin
          capture = 1'b1;
          dir_d   = cand;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (bus.ack) begin
          dir_d   = 4'h0;
          state_d = S_IDLE;
        end
      end
      default: begin
        dir_d   = 4'h0;
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.moved   = (state == S_REQ);
  assign bus.dir_out = dir_q;

endmodule

// File: tb/tb_move_request_gen.sv
// Bench for move_request_gen with DEB_CYCLES=4. A transaction-level model
// tracks each button's raw run length to decide its accepted level, applies
// the resolve/bound/press rules directly, and predicts moved/dir_out after
// every tick/ack pulse. Directed scenarios are followed by random traffic.
module tb_move_request_gen;
  localparam int DEB = 4;

  logic clk = 1'b0;
  logic reset;
  move_request_gen_if bif();

  move_request_gen #(
    .DEB_CYCLES(DEB),
    .CNT_W(3),
    .X_MAX(7'd124),
    .Y_MAX(7'd116)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bif)
  );

  always #5 clk = ~clk;

  int         n_tests = 0;
  int         n_fail  = 0;
  int         req_cnt = 0;
  int         run [4];
  logic [3:0] last_raw;
  logic [3:0] m_stable;
  logic [3:0] m_armed;
  logic [3:0] m_dir;
  logic       m_pend;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] model_cand(input logic [3:0] s, input logic [6:0] x,
                                            input logic [6:0] y, input logic [3:0] arm);
    logic [3:0] r;
    r = s;
    if (s[0] && s[3]) begin r[0] = 1'b0; r[3] = 1'b0; end
    if (s[1] && s[2]) begin r[1] = 1'b0; r[2] = 1'b0; end
    if (x >= 7'd124) r[0] = 1'b0;
    if (x == 7'd0)   r[3] = 1'b0;
    if (y >= 7'd116) r[2] = 1'b0;
    if (y == 7'd0)   r[1] = 1'b0;
    return r & arm;
  endfunction

  // One clock; a button level counts as accepted once held for DEB+2 sampled edges
  task automatic cyc();
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      if (bif.btn_in[i] == last_raw[i]) run[i]++;
      else run[i] = 1;
      last_raw[i] = bif.btn_in[i];
      if (reset) m_stable[i] = 1'b0;
      else if (run[i] >= DEB + 2) m_stable[i] = bif.btn_in[i];
    end
`ifdef AUTO_REPEAT_EN
    m_armed = 4'hF;
`else
    if (reset) m_armed = 4'hF;
    else m_armed = m_armed | ~m_stable;
`endif
  endtask

  task automatic settle(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic pulse(input string tag, input logic t, input logic a);
    logic [3:0] c;
    c = model_cand(m_stable, bif.x_pos, bif.y_pos, m_armed);
    bif.tick = t;
    bif.ack  = a;
    cyc();
    bif.tick = 1'b0;
    bif.ack  = 1'b0;
    if (m_pend) begin
      if (a) m_pend = 1'b0;
    end else if (t && (c != 4'h0)) begin
      m_pend  = 1'b1;
      m_dir   = c;
      m_armed = m_armed & ~c;
      req_cnt++;
    end
    check_eq({tag, ".moved"}, {31'd0, bif.moved}, {31'd0, m_pend});
    check_eq({tag, ".dir"}, {28'd0, bif.dir_out}, {28'd0, (m_pend ? m_dir : 4'h0)});
  endtask

  task automatic press(input logic [3:0] b);
    bif.btn_in = b;
    settle(8);
  endtask

  task automatic do_reset();
    bif.btn_in = 4'h0;
    settle(8);
    reset = 1'b1;
    cyc();
    check_eq("rst.moved", {31'd0, bif.moved}, 32'd0);
    check_eq("rst.dir", {28'd0, bif.dir_out}, 32'd0);
    settle(2);
    reset   = 1'b0;
    m_pend  = 1'b0;
    m_dir   = 4'h0;
    m_armed = 4'hF;
  endtask

  logic [6:0] xs [7] = '{7'd0, 7'd1, 7'd50, 7'd123, 7'd124, 7'd125, 7'd127};
  logic [6:0] ys [7] = '{7'd0, 7'd1, 7'd50, 7'd115, 7'd116, 7'd117, 7'd127};

  initial begin
    int base;
    logic [3:0] b;
    reset      = 1'b1;
    bif.btn_in = 4'h0;
    bif.tick   = 1'b0;
    bif.ack    = 1'b0;
    bif.x_pos  = 7'd50;
    bif.y_pos  = 7'd50;
    last_raw   = 4'h0;
    m_stable   = 4'h0;
    m_armed    = 4'hF;
    m_pend     = 1'b0;
    m_dir      = 4'h0;
    for (int i = 0; i < 4; i++) run[i] = 0;
    settle(3);
    check_eq("init.moved", {31'd0, bif.moved}, 32'd0);
    check_eq("init.dir", {28'd0, bif.dir_out}, 32'd0);
    reset = 1'b0;
    cyc();

    // T1: single right press
    press(4'b0001);
    pulse("t1_tick", 1'b1, 1'b0);
    check_eq("t1_dir_const", {28'd0, bif.dir_out}, 32'h1);
    settle(2);
    check_eq("t1_hold", {31'd0, bif.moved}, 32'd1);
    pulse("t1_ack", 1'b0, 1'b1);
    check_eq("t1_clear", {28'd0, bif.dir_out}, 32'h0);
    press(4'b0000);

    // T2: short glitch rejected, long pulse accepted
    bif.btn_in = 4'b0001;
    settle(3);
    bif.btn_in = 4'b0000;
    settle(8);
    pulse("t2_glitch", 1'b1, 1'b0);
    check_eq("t2_glitch_const", {31'd0, bif.moved}, 32'd0);
    bif.btn_in = 4'b0001;
    settle(6);
    bif.btn_in = 4'b0000;
    settle(1);
    pulse("t2_long", 1'b1, 1'b0);
    check_eq("t2_long_const", {31'd0, bif.moved}, 32'd1);
    pulse("t2_ack", 1'b0, 1'b1);
    press(4'b0000);

    // T3: opposing cancel, diagonal legal
    press(4'b1001);
    pulse("t3_opp", 1'b1, 1'b0);
    check_eq("t3_opp_const", {31'd0, bif.moved}, 32'd0);
    press(4'b0101);
    pulse("t3_diag", 1'b1, 1'b0);
    check_eq("t3_diag_const", {28'd0, bif.dir_out}, 32'h5);
    pulse("t3_ack", 1'b0, 1'b1);
    press(4'b0000);

    // T4: edge masks
    bif.x_pos = 7'd124;
    press(4'b0001);
    pulse("t4_right", 1'b1, 1'b0);
    check_eq("t4_right_const", {31'd0, bif.moved}, 32'd0);
    bif.x_pos = 7'd0;
    press(4'b1000);
    pulse("t4_left", 1'b1, 1'b0);
    check_eq("t4_left_const", {31'd0, bif.moved}, 32'd0);
    bif.x_pos = 7'd50;
    bif.y_pos = 7'd0;
    press(4'b0010);
    pulse("t4_up", 1'b1, 1'b0);
    check_eq("t4_up_const", {31'd0, bif.moved}, 32'd0);
    bif.y_pos = 7'd50;
    press(4'b0000);

    // T5: request frozen against inputs and tick, then reset drops it
    press(4'b0010);
    pulse("t5_tick", 1'b1, 1'b0);
    press(4'b1000);
    bif.x_pos = 7'd0;
    pulse("t5_retick", 1'b1, 1'b0);
    check_eq("t5_frozen", {28'd0, bif.dir_out}, 32'h2);
    bif.x_pos = 7'd50;
    pulse("t5_tick_ack", 1'b1, 1'b1);
    press(4'b0010);
    pulse("t5_tick2", 1'b1, 1'b0);
    do_reset();
    cyc();

    // T6: held down button over three tick/ack rounds
    press(4'b0100);
    base = req_cnt;
    for (int r = 0; r < 3; r++) begin
      pulse("t6_tick", 1'b1, 1'b0);
      if (m_pend) pulse("t6_ack", 1'b0, 1'b1);
      settle(3);
    end
`ifdef AUTO_REPEAT_EN
    check_eq("t6_count", req_cnt - base, 32'd3);
`else
    check_eq("t6_count", req_cnt - base, 32'd1);
    press(4'b0000);
    press(4'b0100);
    pulse("t6_repress", 1'b1, 1'b0);
    check_eq("t6_repress_const", {31'd0, bif.moved}, 32'd1);
    pulse("t6_ack2", 1'b0, 1'b1);
`endif

    // Random traffic against the model
    for (int k = 0; k < 80; k++) begin
      b = 4'($urandom_range(0, 15));
      press(b);
      if ($urandom_range(0, 3) == 0) begin
        bif.btn_in = b ^ 4'($urandom_range(1, 15));
        settle($urandom_range(1, 2));
        bif.btn_in = b;
        settle(8);
      end
      bif.x_pos = xs[$urandom_range(0, 6)];
      bif.y_pos = ys[$urandom_range(0, 6)];
      if ($urandom_range(0, 4) == 0) pulse("rnd_idle_ack", 1'b0, 1'b1);
      pulse("rnd_tick", 1'b1, 1'b0);
      if (m_pend) begin
        settle($urandom_range(0, 3));
        if ($urandom_range(0, 1) == 0) pulse("rnd_req_tick", 1'b1, 1'b0);
        pulse("rnd_ack", 1'($urandom_range(0, 1)), 1'b1);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
